// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, FSM
// encodings, widths and op-classification helpers.
package mdu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the execute stage and the MDU.
interface mdu_if;
  import mdu_pkg::*;

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [1:0]      dbg_state;

  modport master (output start, op, rs1_data, rs2_data,
                  input  busy, done, result, dbg_state);
  modport slave  (input  start, op, rs1_data, rs2_data,
                  output busy, done, result, dbg_state);
endinterface

// File: rtl/mdu_sign_ctl.sv
// Combinational sign handling: operand magnitudes and result sign at start,
// sign correction and word selection at finish.
module mdu_sign_ctl
  import mdu_pkg::*;
(
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] mag_a_o,
  output logic [XLEN-1:0] mag_b_o,
  output logic            neg_o,
  input  logic [2:0]      fin_op_i,
  input  logic            fin_neg_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] lo_i,
  output logic [XLEN-1:0] result_o
);
  logic            sa, sb;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] word;

  assign sa      = is_signed_a(op_i) & rs1_i[XLEN-1];
  assign sb      = is_signed_b(op_i) & rs2_i[XLEN-1];
  assign mag_a_o = sa ? (XLEN'(0) - rs1_i) : rs1_i;
  assign mag_b_o = sb ? (XLEN'(0) - rs2_i) : rs2_i;

  // Remainder follows the dividend; a zero-divisor quotient is never negated
  // so it stays all-ones.
  always_comb begin
    if (is_rem(op_i))                      neg_o = sa;
    else if (is_div(op_i) && rs2_i == '0)  neg_o = 1'b0;
    else                                   neg_o = sa ^ sb;
  end

  assign prod   = {acc_i, lo_i};
  assign prod_s = fin_neg_i ? ((2*XLEN)'(0) - prod) : prod;

  always_comb begin
    word = '0;
    if (!is_div(fin_op_i))     word = (fin_op_i == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else if (is_rem(fin_op_i)) word = fin_neg_i ? (XLEN'(0) - acc_i) : acc_i;
    else                       word = fin_neg_i ? (XLEN'(0) - lo_i) : lo_i;
  end
  assign result_o = word;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit (shift-add / restoring divide).
// Optional MDU_EARLY_OUT_EN skips iteration for zero operands and divide specials.
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  mdu_if.slave bus
);
  // Handshake: start is sampled only in IDLE; busy is high from the accepting
  // edge until the result edge; done pulses one cycle with result valid.
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d, busy_q, busy_d, done_q, done_d, early_q, early_d;
  logic [XLEN-1:0]  acc_q, acc_d, lo_q, lo_d, opa_q, opa_d, result_q, result_d;

  logic [XLEN-1:0]  mag_a, mag_b, fin_result, mcand;
  logic             neg_start;
  logic [XLEN:0]    sum, shifted, diff;

  mdu_sign_ctl u_sign (
    .op_i(bus.op), .rs1_i(bus.rs1_data), .rs2_i(bus.rs2_data),
    .mag_a_o(mag_a), .mag_b_o(mag_b), .neg_o(neg_start),
    .fin_op_i(op_q), .fin_neg_i(neg_q), .acc_i(acc_q), .lo_i(lo_q),
    .result_o(fin_result)
  );

  // acc:lo is the product register (multiply) or remainder:quotient (divide).
  assign mcand   = lo_q[0] ? opa_q : '0;
  assign sum     = {1'b0, acc_q} + {1'b0, mcand};
  assign shifted = {acc_q, lo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, opa_q};

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; op_d = op_q; neg_d = neg_q;
    busy_d = busy_q; done_d = 1'b0; early_d = early_q;
    acc_d = acc_q; lo_d = lo_q; opa_d = opa_q; result_d = result_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        op_d    = bus.op;
        neg_d   = neg_start;
        cnt_d   = '0;
        busy_d  = 1'b1;
        acc_d   = '0;
        lo_d    = is_div(bus.op) ? mag_a : mag_b;
        opa_d   = is_div(bus.op) ? mag_b : mag_a;
        state_d = S_CALC;
`ifdef MDU_EARLY_OUT_EN
        if (is_div(bus.op) && bus.rs2_data == '0) begin
          lo_d = '1; acc_d = mag_a; state_d = S_FINISH; early_d = 1'b1;
        end else if (is_signed_a(bus.op) && is_div(bus.op) &&
                     bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}} && bus.rs2_data == '1) begin
          state_d = S_FINISH; early_d = 1'b1;
        end else if (!is_div(bus.op) && (bus.rs1_data == '0 || bus.rs2_data == '0)) begin
          lo_d = '0; state_d = S_FINISH; early_d = 1'b1;
        end
`endif
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div(op_q)) begin
          if (!diff[XLEN]) begin acc_d = diff[XLEN-1:0];    lo_d = {lo_q[XLEN-2:0], 1'b1}; end
          else             begin acc_d = shifted[XLEN-1:0]; lo_d = {lo_q[XLEN-2:0], 1'b0}; end
        end else begin
          acc_d = sum[XLEN:1];
          lo_d  = {sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        // Early-out spends one settling cycle here so done lands 2 cycles after start.
        if (early_q) early_d = 1'b0;
        else begin
          result_d = fin_result;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE; cnt_q <= '0; op_q <= '0; neg_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; early_q <= 1'b0;
      acc_q <= '0; lo_q <= '0; opa_q <= '0; result_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; op_q <= op_d; neg_q <= neg_d;
      busy_q <= busy_d; done_q <= done_d; early_q <= early_d;
      acc_q <= acc_d; lo_q <= lo_d; opa_q <= opa_d; result_q <= result_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: latency, arithmetic, special
// cases, handshake rules and asynchronous reset.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

`ifdef MDU_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 2;
`else
  localparam int SPECIAL_LAT = 33;
`endif

  mdu_if bus();
  mul_div_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Directed vectors: op, rs1, rs2, expected result, expected latency
  logic [2:0]  v_op  [12] = '{OP_MULH, OP_MULHU, OP_MULHSU, OP_DIV, OP_REM, OP_DIVU, OP_REMU,
                              OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_REM};
  logic [31:0] v_a   [12] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                              32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFFB};
  logic [31:0] v_b   [12] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
  logic [31:0] v_exp [12] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                              32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFB};
  int          v_lat [12] = '{33, 33, 33, 33, 33, 33, 33,
                              SPECIAL_LAT, SPECIAL_LAT, SPECIAL_LAT, SPECIAL_LAT, SPECIAL_LAT};

  task automatic issue_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs1_data = a; bus.rs2_data = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1; res = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = k; res = bus.result; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    total++; if (bus.dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", bus.dbg_state, S_IDLE); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mul_latency();
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.rs1_data = 32'd7; bus.rs2_data = 32'hFFFFFFFD;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k <= 34; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k <= 33) begin
        total++;
        if (bus.busy !== (k <= 32)) begin bad++; $display("FAIL mul_busy cycle=%0d got=%b want=%b", k, bus.busy, (k <= 32)); end
      end
      total++;
      if (bus.done !== (k == 33)) begin bad++; $display("FAIL mul_done cycle=%0d got=%b want=%b", k, bus.done, (k == 33)); end
      if (k == 33) begin
        total++;
        if (bus.result !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_result got=%h want=ffffffeb", bus.result); end
      end
    end
  endtask

  task automatic test_vectors();
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 12; i++) begin
      issue_op(v_op[i], v_a[i], v_b[i], res, lat);
      total++;
      if (res !== v_exp[i]) begin bad++; $display("FAIL vec%0d_result op=%0d got=%h want=%h", i, v_op[i], res, v_exp[i]); end
      total++;
      if (lat != v_lat[i]) begin bad++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, v_lat[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int first_k = -1, second_k = -1, ndone = 0;
    logic [31:0] r1 = 'x, r2 = 'x;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.rs1_data = 32'd3; bus.rs2_data = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.rs1_data = 32'd100; bus.rs2_data = 32'd100;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        if (first_k < 0) begin first_k = k; r1 = bus.result; end
        else begin second_k = k; r2 = bus.result; end
      end
      bus.start = 1'b0;
      if (k == 5 || k == 20) begin
        bus.start = 1'b1; bus.op = OP_DIVU; bus.rs1_data = 32'd9; bus.rs2_data = 32'd3;
      end
      if (k == 33) begin
        bus.start = 1'b1; bus.op = OP_DIVU; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7;
      end
    end
    total++; if (first_k != 33)      begin bad++; $display("FAIL b2b_first_cycle got=%0d want=33", first_k); end
    total++; if (r1 !== 32'd15)      begin bad++; $display("FAIL b2b_first_result got=%h want=0000000f", r1); end
    total++; if (second_k != 67)     begin bad++; $display("FAIL b2b_second_cycle got=%0d want=67", second_k); end
    total++; if (r2 !== 32'd14)      begin bad++; $display("FAIL b2b_second_result got=%h want=0000000e", r2); end
    total++; if (ndone != 2)         begin bad++; $display("FAIL b2b_done_count got=%0d want=2", ndone); end
  endtask

  task automatic test_reset_mid_op();
    int ndone = 0;
    logic [31:0] res;
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #4 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0)    begin bad++; $display("FAIL midrst_done got=%b want=0", bus.done); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL midrst_result got=%h want=0", bus.result); end
    #2 rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL midrst_spurious_done got=%0d want=0", ndone); end
    issue_op(OP_MUL, 32'd3, 32'd4, res, lat);
    total++; if (res !== 32'd12) begin bad++; $display("FAIL midrst_next_result got=%h want=0000000c", res); end
    total++; if (lat != 33)      begin bad++; $display("FAIL midrst_next_latency got=%0d want=33", lat); end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.rs1_data = '0; bus.rs2_data = '0;
    test_reset();
    test_mul_latency();
    test_vectors();
    test_back_to_back();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
